// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: fault codes,
// controller state encoding and the MIPS NOP word.
package imem_pkg;

  typedef enum logic [1:0] {
    IMEM_OK         = 2'b00,
    IMEM_MISALIGNED = 2'b01,
    IMEM_RANGE      = 2'b10,
    IMEM_UNLOADED   = 2'b11
  } imem_fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } imem_state_e;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// combinational read port.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the load counter, so
  // clearing the contents would only cost a reset fan-out to every word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a one-cycle registered fetch port and a streaming
// program-load port that fills the array sequentially from word 0.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(MIPS_NOP),
  localparam int                IW        = $clog2(DEPTH),
  localparam int                CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_instr,
  output logic [1:0]        resp_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              busy,
  output logic [CW-1:0]     load_count
);

  imem_state_e       state_q, state_d;
  logic [CW-1:0]     load_count_q, load_count_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_instr_q, resp_instr_d;
  imem_fault_e       resp_fault_q, resp_fault_d;

  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic [DATA_W-1:0] ram_rdata;
  imem_fault_e       fault;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (load_count_q[IW-1:0]),
    .wdata  (load_data),
    .raddr  (offset[IW+1:2]),
    .rdata  (ram_rdata)
  );

  // Range check uses the full-width index so far addresses never alias.
  always_comb begin
    offset   = req_addr - BASE_ADDR;
    word_idx = offset >> 2;
    if (req_addr[1:0] != 2'b00)                                 fault = IMEM_MISALIGNED;
    else if (req_addr < BASE_ADDR || word_idx >= ADDR_W'(DEPTH)) fault = IMEM_RANGE;
    else if (word_idx >= ADDR_W'(load_count_q))                  fault = IMEM_UNLOADED;
    else                                                         fault = IMEM_OK;
  end

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign ram_we    = (state_q == LOAD) && load_valid;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    unique case (state_q)
      IDLE: if (load_start) begin
        state_d      = LOAD;
        load_count_d = '0;
      end
      LOAD: if (load_valid) begin
        load_count_d = load_count_q + 1'b1;
        if (load_last || load_count_q == CW'(DEPTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A fetch in the same cycle as load_start sees the pre-load count and contents.
  always_comb begin
    resp_valid_d = accept;
    resp_instr_d = resp_instr_q;
    resp_fault_d = resp_fault_q;
    if (accept) begin
      resp_fault_d = fault;
      resp_instr_d = (fault == IMEM_OK) ? ram_rdata : NOP_INSTR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      load_count_q <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_fault_q <= IMEM_OK;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_fault = resp_fault_q;
  assign load_count = load_count_q;
  assign load_done  = (state_q == DONE);
  assign busy       = (state_q == LOAD);

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable (DEPTH=64, BASE 0) plus a
// second instance at BASE_ADDR=0x400000 for the below-base range check.
module tb_imem_loadable;

  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic [1:0]  resp_fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_done;
  logic        busy;
  logic [CW-1:0] load_count;

  logic        b_req_valid;
  logic [31:0] b_req_addr;
  logic        b_req_ready;
  logic        b_resp_valid;
  logic [31:0] b_resp_instr;
  logic [1:0]  b_resp_fault;
  logic        b_load_done;
  logic        b_busy;
  logic [CW-1:0] b_load_count;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int done_pulses;

  always #5 clk = ~clk;

  imem_loadable #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_instr (resp_instr),
    .resp_fault (resp_fault),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_done  (load_done),
    .busy       (busy),
    .load_count (load_count)
  );

  imem_loadable #(.DEPTH(DEPTH), .BASE_ADDR(32'h0040_0000)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (b_req_valid),
    .req_addr   (b_req_addr),
    .req_ready  (b_req_ready),
    .resp_valid (b_resp_valid),
    .resp_instr (b_resp_instr),
    .resp_fault (b_resp_fault),
    .load_start (1'b0),
    .load_valid (1'b0),
    .load_data  (32'h0),
    .load_last  (1'b0),
    .load_done  (b_load_done),
    .busy       (b_busy),
    .load_count (b_load_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; req_addr = 0; load_start = 0;
    load_valid = 0; load_data = 0; load_last = 0;
    b_req_valid = 0; b_req_addr = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_instr", resp_instr, 0);
    check("rst_resp_fault", resp_fault, 0);
    check("rst_busy", busy, 0);
    check("rst_load_count", load_count, 0);
    check("rst_load_done", load_done, 0);
    check("rst_req_ready", req_ready, 1);

    // Fetch before any load: unloaded.
    req_valid = 1; req_addr = 32'h0;
    tick();
    req_valid = 0;
    check("unl_valid", resp_valid, 1);
    check("unl_fault", resp_fault, 2'b11);
    check("unl_instr", resp_instr, 32'h0);
    tick();
    check("idle_valid_low", resp_valid, 0);
    check("idle_fault_hold", resp_fault, 2'b11);

    // Load three words while holding a fetch request; load_start in LOAD ignored.
    load_start = 1;
    tick();
    check("ld_busy", busy, 1);
    check("ld_ready", req_ready, 0);
    check("ld_count0", load_count, 0);
    req_valid = 1; req_addr = 32'h0;
    load_valid = 1; load_data = 32'h0123_4820; // load_start still high
    tick();
    load_start = 0;
    check("ld_count1", load_count, 1);
    check("ld_no_resp1", resp_valid, 0);
    load_data = 32'h8C09_0004;
    tick();
    check("ld_count2", load_count, 2);
    load_data = 32'h1000_FFFF; load_last = 1;
    tick();
    load_valid = 0; load_last = 0;
    check("done_pulse", load_done, 1);
    check("done_ready", req_ready, 0);
    check("done_busy", busy, 0);
    check("done_count", load_count, 3);
    check("done_no_resp", resp_valid, 0);
    tick();
    check("post_done_low", load_done, 0);
    check("post_done_no_resp", resp_valid, 0);
    check("post_done_ready", req_ready, 1);

    // Back-to-back fetches (request for 0x0 already held).
    tick();
    req_addr = 32'h4;
    check("f0_valid", resp_valid, 1);
    check("f0_instr", resp_instr, 32'h0123_4820);
    check("f0_fault", resp_fault, 0);
    tick();
    req_addr = 32'h8;
    check("f4_valid", resp_valid, 1);
    check("f4_instr", resp_instr, 32'h8C09_0004);
    tick();
    req_addr = 32'hC;
    check("f8_instr", resp_instr, 32'h1000_FFFF);
    check("f8_fault", resp_fault, 0);
    tick();
    req_addr = 32'h6;
    check("fC_fault", resp_fault, 2'b11);
    check("fC_instr", resp_instr, 32'h0);
    tick();
    req_addr = 32'h100;
    check("f6_fault", resp_fault, 2'b01);
    check("f6_instr", resp_instr, 32'h0);
    tick();
    req_valid = 0;
    check("f100_fault", resp_fault, 2'b10);
    check("f100_valid", resp_valid, 1);
    tick();
    check("f_idle_valid", resp_valid, 0);

    // Below-base and first-word fetches on the offset instance.
    b_req_valid = 1; b_req_addr = 32'h003F_FFFC;
    tick();
    b_req_addr = 32'h0040_0000;
    check("base_below_fault", b_resp_fault, 2'b10);
    check("base_below_instr", b_resp_instr, 32'h0);
    tick();
    b_req_valid = 0;
    check("base_w0_fault", b_resp_fault, 2'b11);
    check("base_w0_valid", b_resp_valid, 1);

    // Same-cycle load_start and fetch: old word, old count.
    req_valid = 1; req_addr = 32'h4; load_start = 1;
    tick();
    req_valid = 0; load_start = 0;
    check("same_instr", resp_instr, 32'h8C09_0004);
    check("same_fault", resp_fault, 0);
    check("same_busy", busy, 1);
    check("same_count", load_count, 0);

    // Stream DEPTH+2 words with no load_last.
    done_pulses = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_valid = 1; load_data = 32'hA500_0000 + i;
      tick();
      if (load_done) done_pulses++;
    end
    load_valid = 0;
    check("full_done_once", done_pulses, 1);
    check("full_count", load_count, DEPTH);
    check("full_busy", busy, 0);
    req_valid = 1; req_addr = 32'hFC;
    tick();
    req_addr = 32'h0;
    check("full_last_instr", resp_instr, 32'hA500_003F);
    check("full_last_fault", resp_fault, 0);
    tick();
    req_valid = 0;
    check("full_w0_instr", resp_instr, 32'hA500_0000);

    // Reset after 5 of 10 words.
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = 32'hBEEF_0000 + i;
      tick();
    end
    check("mid_count5", load_count, 5);
    reset = 1;
    tick();
    reset = 0; load_valid = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", load_count, 0);
    check("mid_rst_ready", req_ready, 1);
    req_valid = 1; req_addr = 32'h0;
    tick();
    req_valid = 0;
    check("mid_rst_fault", resp_fault, 2'b11);
    check("mid_rst_instr", resp_instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory for the single-cycle/pipelined MIPS datapath.
- Byte-addressed, word-aligned fetch port with a registered one-cycle response and a fault code.
- A streaming program-load port writes the program sequentially from word 0 after reset, replacing hard-coded initial contents.
- Sits between the PC/fetch stage and the testbench or boot loader.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, byte-address width of the fetch port.
- DEPTH, 64, number of instruction words; power of two, >= 2.
- BASE_ADDR, 0, byte address of word 0; must be a multiple of 4.
- NOP_INSTR, 32'h0000_0000, instruction returned on any fault.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_W  fetch byte address.
- req_ready  out  1  fetch accepted this cycle when high with req_valid.
- resp_valid  out  1  response valid; a one-cycle pulse per accepted request.
- resp_instr  out  DATA_W  fetched instruction, or NOP_INSTR on fault.
- resp_fault  out  2  fault code: 00 ok, 01 misaligned, 10 out of range, 11 unloaded.
- load_start  in  1  pulse that begins a program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  next program word.
- load_last  in  1  marks the final word; qualified by load_valid.
- load_done  out  1  one-cycle pulse when a load completes.
- busy  out  1  high while in LOAD.
- load_count  out  clog2(DEPTH)+1  number of words loaded so far.

Behaviour:
- Reset: state=IDLE; load_count=0; resp_valid=0; resp_instr=0; resp_fault=00; load_done=0; busy=0.
- Memory array contents are not reset. The load_count=0 value makes every word read as unloaded.
- States:
  - IDLE: req_ready=1.
  - LOAD: req_ready=0, busy=1.
  - DONE: lasts one cycle; load_done=1, req_ready=0; always returns to IDLE.
- IDLE→LOAD on load_start. The same edge clears load_count to 0.
- LOAD, each load_valid cycle: mem[load_count] <= load_data; load_count <= load_count+1.
- LOAD→DONE on the edge where load_valid&&load_last, or where the write fills word DEPTH-1 (load_count becomes DEPTH).
- load_valid is ignored outside LOAD. load_start is ignored in LOAD and DONE.
- Fetch is accepted when req_valid&&req_ready.
  - Index = (req_addr-BASE_ADDR)>>2.
  - On the next edge: resp_valid=1, resp_instr/resp_fault are registered.
  - Latency is exactly 1 cycle. There is no response backpressure.
- Fault priority:
  - 01 if req_addr[1:0]!=0.
  - else 10 if req_addr<BASE_ADDR or index>=DEPTH.
  - else 11 if index>=load_count.
  - else 00.
- On any fault, resp_instr=NOP_INSTR.
- Range checking uses the full ADDR_W subtraction; the index is never truncated before the check.
- Non-accepted cycles: resp_valid=0; resp_instr and resp_fault hold their previous values.
- Same-cycle fetch and load_start in IDLE: both are honoured. The fetch response uses the pre-load load_count, i.e. the old contents and old count.
- Back-to-back fetches in IDLE yield one response per cycle.
- Reset mid-load: returns to IDLE with load_count=0. Partially written words read as fault 11.
- A load of DEPTH words without load_last ends on word DEPTH-1. No write occurs past the array.

Decomposition:
- Shared package (imem_pkg):
  - fault code constants IMEM_OK, IMEM_MISALIGNED, IMEM_RANGE, IMEM_UNLOADED;
  - state encoding IDLE/LOAD/DONE;
  - MIPS NOP constant.
- One natural sub-module, imem_ram: a single-port-write, single-port-read register array, DEPTH x DATA_W, with a synchronous write and a combinational read.
- The FSM, load counter, address decode and fault logic stay in the top level.

Test Plan:
- Reset, then fetch 0x0 → resp_valid one cycle later; resp_fault=11; resp_instr=0x00000000.
- Load 3 words (0x01234820, 0x8C090004, 0x1000FFFF) with load_last on the third → load_done pulses on the cycle after the third write.
  - Fetches at 0x0, 0x4, 0x8 in consecutive cycles return those words with fault 00, one per cycle.
  - A fetch at 0xC returns fault 11.
- Fetch 0x6 → fault 01, NOP. With DEPTH=64, fetch 0x100 → fault 10. With BASE_ADDR=0x400000, fetch 0x3FFFFC → fault 10.
- During LOAD, hold req_valid=1 → req_ready=0 and no resp_valid until the cycle after DONE. load_start during LOAD has no effect.
- Stream DEPTH+2 words with no load_last → exactly DEPTH writes; load_count=DEPTH; load_done pulses once. The extra words are ignored, and fetch (DEPTH-1)*4 returns the last written word.
- Assert reset after 5 of 10 words → IDLE; load_count=0; busy=0; fetch 0x0 returns fault 11.
- Same-cycle load_start and fetch of 0x4 after a prior load → response returns the old word with fault 00.
